exc_pipe: RTL and testbench

Exception-tracking pipeline that produces the per-instruction exception record consumed by CP0. It carries fault information alongside each instruction from F through D and E into an M-stage record, applying MIPS in-instruction priority. It drives CP0's `reg_valid`/`pre_*` inputs and takes CP0's `exc_occur`/`pc` back to flush the pipeline and redirect fetch. It also tells the memory stage when a store must be suppressed.

---
 rtl/exc_pipe_pkg.sv | 54 +++++
 rtl/exc_stage_reg.sv | 65 ++++++
 rtl/exc_pipe.sv | 173 +++++++++++++++++
 tb/tb_exc_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pipe_pkg.sv
// Shared CP0 definitions: exception codes, record field widths, the per-stage exception record.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: ExcCode_* constants, field widths, exc_rec_t, misaligned(), idle_rec().
package exc_pipe_pkg;

  localparam int PC_W       = 32;
  localparam int BADVADDR_W = 32;
  localparam int EXCCODE_W  = 5;

  localparam logic [EXCCODE_W-1:0] ExcCode_AdEL    = 5'd4;
  localparam logic [EXCCODE_W-1:0] ExcCode_AdES    = 5'd5;
  localparam logic [EXCCODE_W-1:0] ExcCode_Sys     = 5'd8;
  localparam logic [EXCCODE_W-1:0] ExcCode_Bp      = 5'd9;
  localparam logic [EXCCODE_W-1:0] ExcCode_RI      = 5'd10;
  localparam logic [EXCCODE_W-1:0] ExcCode_Ov      = 5'd12;
  // "No exception" marker; ERET also reports this code while raising is_exc.
  localparam logic [EXCCODE_W-1:0] ExcCode_RESERVE = 5'd31;

  typedef struct packed {
    logic                  valid;
    logic [PC_W-1:0]       pc;
    logic                  is_in_ds;
    logic                  is_eret;
    logic                  is_exc;
    logic [EXCCODE_W-1:0]  exc_code;
    logic [BADVADDR_W-1:0] badvaddr;
  } exc_rec_t;

  // Data access alignment: half needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
    logic mis;
    case (size)
      2'd1:    mis = addr[0];
      2'd2:    mis = (addr[1:0] != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Empty record: no instruction, no fault. The pc field is carried for visibility only.
  function automatic exc_rec_t idle_rec(input logic [PC_W-1:0] pc);
    exc_rec_t r;
    r.valid    = 1'b0;
    r.pc       = pc;
    r.is_in_ds = 1'b0;
    r.is_eret  = 1'b0;
    r.is_exc   = 1'b0;
    r.exc_code = ExcCode_RESERVE;
    r.badvaddr = '0;
    return r;
  endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// One pipeline exception-record register: load enable, bubble insertion, flush, fault merge.
// Latency: 1 cycle from upstream record (+ merge) to rec_q.
// Backpressure: holds while en=0; inserts a bubble when loading while upstream holds; flush wins.
// Ports: en/up_adv/flush control; up_rec upstream record; merge_* candidate fault for this hop;
//        ds_ld/ds_val optional delay-slot override; rec_q_o registered record; merged_o comb view.
module exc_stage_reg
  import exc_pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  up_adv,
  input  logic                  flush,
  input  exc_rec_t              up_rec,
  input  logic                  merge_exc,
  input  logic                  merge_eret,
  input  logic [EXCCODE_W-1:0]  merge_code,
  input  logic [BADVADDR_W-1:0] merge_badvaddr,
  input  logic                  ds_ld,
  input  logic                  ds_val,
  output exc_rec_t              rec_q_o,
  output exc_rec_t              merged_o
);

  exc_rec_t rec_q;
  exc_rec_t rec_d;
  exc_rec_t merged;

  always_comb begin
    merged = up_rec;
    // An existing fault is never overwritten; bubbles never pick up faults.
    if (up_rec.valid && !up_rec.is_exc && merge_exc) begin
      merged.is_exc   = 1'b1;
      merged.is_eret  = merge_eret;
      merged.exc_code = merge_code;
      merged.badvaddr = merge_badvaddr;
    end
    if (ds_ld) begin
      merged.is_in_ds = ds_val;
    end
  end

  always_comb begin
    rec_d = rec_q;
    if (flush) begin
      rec_d = idle_rec(rec_q.pc);
    end else if (en) begin
      rec_d = up_adv ? merged : idle_rec(merged.pc);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rec_q <= idle_rec(RESET_PC);
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_q_o  = rec_q;
  assign merged_o = merged;

endmodule

// File: rtl/exc_pipe.sv
// Exception-tracking pipeline F->D->E->M producing the CP0 exception record, with flush/redirect.
// Latency: fetch fault visible on pre_* 3 cycles later; mem_kill/flush/redirect_* combinational.
// Backpressure: stage enables from the hazard unit hold/bubble stages; exc_occur flushes all.
// Ports: clk/resetn; fd_en/de_en/em_en; F/D/E fault inputs; exc_occur/cp0_pc from CP0;
//        reg_valid + pre_* M record to CP0; mem_kill to memory stage; flush/redirect_* to fetch.
// Option: define EXC_ADDR_CHECK_EN to enable fetch and data address-alignment checks.
module exc_pipe
  import exc_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fd_en,
  input  logic        de_en,
  input  logic        em_en,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        d_ri,
  input  logic        d_sys,
  input  logic        d_bp,
  input  logic        d_eret,
  input  logic        d_is_in_ds,
  input  logic        e_ov,
  input  logic        e_is_load,
  input  logic        e_is_store,
  input  logic [1:0]  e_size,
  input  logic [31:0] e_addr,
  input  logic        exc_occur,
  input  logic [31:0] cp0_pc,
  output logic        reg_valid,
  output logic [31:0] pre_pc,
  output logic [31:0] pre_badvaddr,
  output logic [4:0]  pre_excCode,
  output logic        pre_is_exc,
  output logic        pre_is_in_ds,
  output logic        pre_is_eret,
  output logic        mem_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  exc_rec_t f_rec;
  exc_rec_t d_rec;
  exc_rec_t e_rec;
  exc_rec_t m_rec;
  exc_rec_t e_merged;
  exc_rec_t unused_f_merged;
  exc_rec_t unused_d_merged;

  logic                  f_adel;
  logic                  e_addr_fault;
  logic [BADVADDR_W-1:0] e_fault_badvaddr;

`ifdef EXC_ADDR_CHECK_EN
  assign f_adel           = (f_pc[1:0] != 2'b00);
  assign e_addr_fault     = (e_is_load | e_is_store) & misaligned(e_size, e_addr);
  assign e_fault_badvaddr = e_addr;
`else
  logic unused_addr_inputs;
  assign f_adel             = 1'b0;
  assign e_addr_fault       = 1'b0;
  assign e_fault_badvaddr   = '0;
  assign unused_addr_inputs = ^{e_size, e_addr};
`endif

  // Record entering D straight from fetch.
  always_comb begin
    f_rec       = idle_rec(f_pc);
    f_rec.valid = f_valid;
  end

  // Decode faults in MIPS priority order; ERET raises is_exc with the RESERVE code.
  logic                 d_exc;
  logic                 d_eret_only;
  logic [EXCCODE_W-1:0] d_code;

  always_comb begin
    d_exc       = d_ri | d_sys | d_bp | d_eret;
    d_eret_only = d_eret & ~(d_ri | d_sys | d_bp);
    if (d_ri)       d_code = ExcCode_RI;
    else if (d_sys) d_code = ExcCode_Sys;
    else if (d_bp)  d_code = ExcCode_Bp;
    else            d_code = ExcCode_RESERVE;
  end

  // Execute faults: overflow outranks the data address error.
  logic                  e_exc;
  logic [EXCCODE_W-1:0]  e_code;
  logic [BADVADDR_W-1:0] e_badvaddr;

  always_comb begin
    e_exc = e_ov | e_addr_fault;
    if (e_ov) begin
      e_code     = ExcCode_Ov;
      e_badvaddr = '0;
    end else begin
      e_code     = e_is_load ? ExcCode_AdEL : ExcCode_AdES;
      e_badvaddr = e_fault_badvaddr;
    end
  end

  // D register: fetch is always "advancing"; its validity is f_valid itself.
  exc_stage_reg #(.RESET_PC(RESET_PC)) u_d_reg (
    .clk            (clk),
    .resetn         (resetn),
    .en             (fd_en),
    .up_adv         (1'b1),
    .flush          (exc_occur),
    .up_rec         (f_rec),
    .merge_exc      (f_adel),
    .merge_eret     (1'b0),
    .merge_code     (ExcCode_AdEL),
    .merge_badvaddr (f_pc),
    .ds_ld          (1'b0),
    .ds_val         (1'b0),
    .rec_q_o        (d_rec),
    .merged_o       (unused_f_merged)
  );

  // E register: merges decode faults and latches the delay-slot flag.
  exc_stage_reg #(.RESET_PC(RESET_PC)) u_e_reg (
    .clk            (clk),
    .resetn         (resetn),
    .en             (de_en),
    .up_adv         (fd_en),
    .flush          (exc_occur),
    .up_rec         (d_rec),
    .merge_exc      (d_exc),
    .merge_eret     (d_eret_only),
    .merge_code     (d_code),
    .merge_badvaddr ('0),
    .ds_ld          (1'b1),
    .ds_val         (d_is_in_ds),
    .rec_q_o        (e_rec),
    .merged_o       (unused_d_merged)
  );

  // M register: merges execute faults; its merged view also drives store suppression.
  exc_stage_reg #(.RESET_PC(RESET_PC)) u_m_reg (
    .clk            (clk),
    .resetn         (resetn),
    .en             (em_en),
    .up_adv         (de_en),
    .flush          (exc_occur),
    .up_rec         (e_rec),
    .merge_exc      (e_exc),
    .merge_eret     (1'b0),
    .merge_code     (e_code),
    .merge_badvaddr (e_badvaddr),
    .ds_ld          (1'b0),
    .ds_val         (1'b0),
    .rec_q_o        (m_rec),
    .merged_o       (e_merged)
  );

  assign reg_valid    = m_rec.valid;
  assign pre_pc       = m_rec.pc;
  assign pre_badvaddr = m_rec.badvaddr;
  assign pre_excCode  = m_rec.exc_code;
  assign pre_is_exc   = m_rec.is_exc;
  assign pre_is_in_ds = m_rec.is_in_ds;
  assign pre_is_eret  = m_rec.is_eret;

  // A faulting store, or any store behind a faulting M instruction, must not write.
  assign mem_kill = (e_rec.valid & e_merged.is_exc) | (m_rec.valid & m_rec.is_exc);

  assign flush          = exc_occur;
  assign redirect_valid = exc_occur;
  assign redirect_pc    = cp0_pc;

endmodule

// File: tb/tb_exc_pipe.sv
module tb_exc_pipe;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [4:0]  C_ADEL = 5'd4;
  localparam logic [4:0]  C_ADES = 5'd5;
  localparam logic [4:0]  C_SYS  = 5'd8;
  localparam logic [4:0]  C_BP   = 5'd9;
  localparam logic [4:0]  C_RI   = 5'd10;
  localparam logic [4:0]  C_OV   = 5'd12;
  localparam logic [4:0]  C_RES  = exc_pipe_pkg::ExcCode_RESERVE;
`ifdef EXC_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, fd_en, de_en, em_en, f_valid;
  logic [31:0] f_pc;
  logic        d_ri, d_sys, d_bp, d_eret, d_is_in_ds;
  logic        e_ov, e_is_load, e_is_store;
  logic [1:0]  e_size;
  logic [31:0] e_addr;
  logic        exc_occur;
  logic [31:0] cp0_pc;
  logic        reg_valid, pre_is_exc, pre_is_in_ds, pre_is_eret;
  logic [31:0] pre_pc, pre_badvaddr, redirect_pc;
  logic [4:0]  pre_excCode;
  logic        mem_kill, flush, redirect_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_pipe #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
    .f_valid(f_valid), .f_pc(f_pc),
    .d_ri(d_ri), .d_sys(d_sys), .d_bp(d_bp), .d_eret(d_eret), .d_is_in_ds(d_is_in_ds),
    .e_ov(e_ov), .e_is_load(e_is_load), .e_is_store(e_is_store), .e_size(e_size), .e_addr(e_addr),
    .exc_occur(exc_occur), .cp0_pc(cp0_pc),
    .reg_valid(reg_valid), .pre_pc(pre_pc), .pre_badvaddr(pre_badvaddr), .pre_excCode(pre_excCode),
    .pre_is_exc(pre_is_exc), .pre_is_in_ds(pre_is_in_ds), .pre_is_eret(pre_is_eret),
    .mem_kill(mem_kill), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Reference model: each pipeline slot holds an instruction with every fault
  // attribute it has collected; the exception record is derived from the
  // architectural priority list only when needed.
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        ds, ri, sys, bp, eret, ov, ld, st;
    logic [1:0]  size;
    logic [31:0] addr;
  } ins_t;

  ins_t md, me, mm;

  function automatic void classify(input ins_t i, output logic x, output logic [4:0] c,
                                   output logic [31:0] b, output logic er);
    logic mis;
    mis = (i.size == 2'd1 && i.addr[0]) || (i.size == 2'd2 && i.addr[1:0] != 2'b00);
    x = 1'b1; b = 32'h0; er = 1'b0; c = C_RES;
    if (CHK && i.pc[1:0] != 2'b00) begin c = C_ADEL; b = i.pc; end
    else if (i.ri)   c = C_RI;
    else if (i.sys)  c = C_SYS;
    else if (i.bp)   c = C_BP;
    else if (i.eret) er = 1'b1;
    else if (i.ov)   c = C_OV;
    else if (CHK && (i.ld || i.st) && mis) begin c = i.ld ? C_ADEL : C_ADES; b = i.addr; end
    else x = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    resetn = 1'b1; fd_en = 1'b1; de_en = 1'b1; em_en = 1'b1;
    f_valid = 1'b0; f_pc = 32'h8000_0000;
    d_ri = 0; d_sys = 0; d_bp = 0; d_eret = 0; d_is_in_ds = 0;
    e_ov = 0; e_is_load = 0; e_is_store = 0; e_size = 2'd0; e_addr = 32'h0;
    exc_occur = 1'b0; cp0_pc = 32'h0;
  endtask

  // Checks combinational outputs against current inputs, clocks once,
  // advances the model, then checks the registered M record.
  task automatic cycle();
    ins_t cur_e, nd, ne, nm;
    logic xe, xm, er;
    logic [4:0] c;
    logic [31:0] b;
    #1;
    cur_e = me;
    cur_e.ov = e_ov; cur_e.ld = e_is_load; cur_e.st = e_is_store;
    cur_e.size = e_size; cur_e.addr = e_addr;
    classify(cur_e, xe, c, b, er);
    classify(mm, xm, c, b, er);
    chk("mem_kill", mem_kill, (me.v & xe) | (mm.v & xm));
    chk("flush", flush, exc_occur);
    chk("redirect_valid", redirect_valid, exc_occur);
    chk("redirect_pc", redirect_pc, cp0_pc);
    @(posedge clk);
    nd = md; ne = me; nm = mm;
    if (!resetn || exc_occur) begin
      nd.v = 0; ne.v = 0; nm.v = 0;
    end else begin
      if (em_en) begin
        if (de_en) nm = cur_e; else nm.v = 1'b0;
      end
      if (de_en) begin
        if (fd_en) begin
          ne = md;
          ne.ri = d_ri; ne.sys = d_sys; ne.bp = d_bp; ne.eret = d_eret; ne.ds = d_is_in_ds;
        end else ne.v = 1'b0;
      end
      if (fd_en) begin
        nd = '0; nd.v = f_valid; nd.pc = f_pc;
      end
    end
    md = nd; me = ne; mm = nm;
    #1;
    chk("reg_valid", reg_valid, mm.v);
    if (mm.v) begin
      classify(mm, xm, c, b, er);
      chk("pre_pc", pre_pc, mm.pc);
      chk("pre_is_exc", pre_is_exc, xm);
      chk("pre_excCode", pre_excCode, c);
      chk("pre_badvaddr", pre_badvaddr, b);
      chk("pre_is_eret", pre_is_eret, er);
      chk("pre_is_in_ds", pre_is_in_ds, mm.ds);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_reg_valid", reg_valid, 0);
    chk("rst_pre_pc", pre_pc, RST_PC);
    chk("rst_pre_excCode", pre_excCode, C_RES);
    chk("rst_pre_badvaddr", pre_badvaddr, 0);
    chk("rst_pre_is_exc", pre_is_exc, 0);
    chk("rst_pre_is_eret", pre_is_eret, 0);
    chk("rst_pre_is_in_ds", pre_is_in_ds, 0);
    chk("rst_mem_kill", mem_kill, 0);
    chk("rst_flush", flush, 0);
  endtask

  initial begin
    md = '0; me = '0; mm = '0;
    idle();
    // Reset
    resetn = 1'b0;
    cycle(); cycle();
    chk_reset_state();
    idle();

    // Fetch AdEL travels to M in three cycles
    f_valid = 1; f_pc = 32'hBFC0_0002; cycle();
    idle(); cycle(); cycle();
    chk("adel_is_exc", pre_is_exc, CHK ? 1 : 0);
    chk("adel_code", pre_excCode, CHK ? C_ADEL : C_RES);
    chk("adel_badvaddr", pre_badvaddr, CHK ? 32'hBFC0_0002 : 32'h0);

    // RI in D beats Ov in E
    idle(); f_valid = 1; f_pc = 32'h8000_0010; cycle();
    idle(); d_ri = 1; cycle();
    idle(); e_ov = 1; cycle();
    idle();
    chk("ri_wins_code", pre_excCode, C_RI);
    chk("ri_wins_badvaddr", pre_badvaddr, 0);

    // Misaligned word store
    f_valid = 1; f_pc = 32'h8000_0020; cycle();
    idle(); cycle();
    idle(); e_is_store = 1; e_size = 2'd2; e_addr = 32'h8000_0006;
    #1 chk("store_mem_kill", mem_kill, CHK ? 1 : 0);
    cycle();
    idle();
    chk("store_code", pre_excCode, CHK ? C_ADES : C_RES);
    chk("store_badvaddr", pre_badvaddr, CHK ? 32'h8000_0006 : 32'h0);

    // ERET in delay slot, then CP0 flush/redirect
    f_valid = 1; f_pc = 32'h8000_0030; cycle();
    idle(); d_eret = 1; d_is_in_ds = 1; f_valid = 1; f_pc = 32'h8000_0034; cycle();
    idle(); f_valid = 1; f_pc = 32'h8000_0038; cycle();
    chk("eret_is_exc", pre_is_exc, 1);
    chk("eret_is_eret", pre_is_eret, 1);
    chk("eret_in_ds", pre_is_in_ds, 1);
    idle(); f_valid = 1; f_pc = 32'h8000_003C; exc_occur = 1; cp0_pc = 32'h8000_1000;
    #1 chk("eret_redirect_pc", redirect_pc, 32'h8000_1000);
    cycle();
    chk("eret_flushed_valid", reg_valid, 0);
    idle(); cycle(); cycle();
    chk("eret_pipe_empty", reg_valid, 0);

    // Flush beats load
    for (int i = 0; i < 3; i++) begin
      idle(); f_valid = 1; f_pc = 32'h8000_0100 + 32'(4 * i); cycle();
    end
    idle(); f_valid = 1; f_pc = 32'h8000_0200; exc_occur = 1; cp0_pc = 32'hBFC0_0380; cycle();
    chk("flush_beats_load", reg_valid, 0);
    idle(); cycle();
    chk("flush_e_cleared", reg_valid, 0);

    // Bubble: E loads while D holds
    idle(); f_valid = 1; f_pc = 32'h8000_0300; cycle();
    idle(); f_valid = 1; f_pc = 32'h8000_0304; cycle();
    idle(); fd_en = 0; em_en = 0; cycle();
    idle(); fd_en = 0; de_en = 0; cycle();
    chk("bubble_reaches_m", reg_valid, 0);
    idle(); fd_en = 0; cycle();
    idle(); cycle();

    // Reset while M holds a fault
    idle(); f_valid = 1; f_pc = 32'h8000_0400; cycle();
    idle(); d_sys = 1; cycle();
    idle(); cycle();
    idle(); em_en = 0; de_en = 0; fd_en = 0; cycle(); cycle();
    chk("stall_hold_code", pre_excCode, C_SYS);
    resetn = 0; cycle();
    chk_reset_state();
    idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0] mem_kind;
      resetn     = ($urandom_range(0, 63) != 0);
      fd_en      = ($urandom_range(0, 3) != 0);
      de_en      = ($urandom_range(0, 3) != 0);
      em_en      = ($urandom_range(0, 3) != 0);
      f_valid    = ($urandom_range(0, 3) != 0);
      f_pc       = {$urandom_range(0, 32'hFFFF), 14'h0, 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)};
      d_ri       = ($urandom_range(0, 9) == 0);
      d_sys      = ($urandom_range(0, 9) == 0);
      d_bp       = ($urandom_range(0, 9) == 0);
      d_eret     = ($urandom_range(0, 9) == 0);
      d_is_in_ds = ($urandom_range(0, 3) == 0);
      e_ov       = ($urandom_range(0, 7) == 0);
      mem_kind   = 3'($urandom_range(0, 3));
      e_is_load  = (mem_kind == 3'd1);
      e_is_store = (mem_kind == 3'd2);
      e_size     = 2'($urandom_range(0, 2));
      e_addr     = $urandom;
      exc_occur  = ($urandom_range(0, 15) == 0);
      cp0_pc     = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
